// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg -- shared types and constants for the SRAM round-robin arbiter.
//   ADDR_W / DATA_W : SRAM word address and data widths (256K x 16 part)
//   N_REQ           : number of requesters sharing the SRAM
//   state_t         : sequencer states
//   strobe_t        : active-low chip/output/write enable triple, with one
//                     constant per phase of the access
`timescale 1ns/1ps
package sram_arb_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int N_REQ  = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
  } strobe_t;

  localparam strobe_t STB_IDLE     = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
  localparam strobe_t STB_READ     = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};
  localparam strobe_t STB_WR_SETUP = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1};
  localparam strobe_t STB_WR_PULSE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};
  localparam strobe_t STB_WR_HOLD  = STB_WR_SETUP;

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// sram_rr_arbiter_if -- requester-side bus of the SRAM arbiter.
//   m_req[i]    request from requester i
//   m_we[i]     1 = write, 0 = read (qualified by m_req[i])
//   m_addr      requester i address at [i*ADDR_W +: ADDR_W]
//   m_wdata     requester i write data at [i*DATA_W +: DATA_W]
//   m_be        requester i byte enables at [2i+1:2i], bit1 = upper byte
//               (present only when SRAM_ARB_BE_EN is defined)
//   m_ack[i]    one-cycle accept pulse
//   m_rvalid[i] one-cycle read-data-valid pulse
//   m_rdata     shared read data, meaningful while an m_rvalid bit is high
// Modports: master = requester side, slave = arbiter side.
`timescale 1ns/1ps
interface sram_rr_arbiter_if;
  import sram_arb_pkg::*;

  logic [N_REQ-1:0]        m_req;
  logic [N_REQ-1:0]        m_we;
  logic [N_REQ*ADDR_W-1:0] m_addr;
  logic [N_REQ*DATA_W-1:0] m_wdata;
`ifdef SRAM_ARB_BE_EN
  logic [2*N_REQ-1:0]      m_be;
`endif
  logic [N_REQ-1:0]        m_ack;
  logic [N_REQ-1:0]        m_rvalid;
  logic [DATA_W-1:0]       m_rdata;

`ifdef SRAM_ARB_BE_EN
  modport master (output m_req, m_we, m_addr, m_wdata, m_be,
                  input  m_ack, m_rvalid, m_rdata);
  modport slave  (input  m_req, m_we, m_addr, m_wdata, m_be,
                  output m_ack, m_rvalid, m_rdata);
`else
  modport master (output m_req, m_we, m_addr, m_wdata,
                  input  m_ack, m_rvalid, m_rdata);
  modport slave  (input  m_req, m_we, m_addr, m_wdata,
                  output m_ack, m_rvalid, m_rdata);
`endif

endinterface

// File: rtl/sram_dq_io.sv
// sram_dq_io -- data-pin handling for the SRAM sequencer.
//   clk, rst_n  clock, asynchronous active-low reset
//   load_wr     capture wdata and start driving the bus on the next cycle
//   release_wr  stop driving the bus (ignored when load_wr is also high)
//   capture     sample the bus into rdata at this edge
//   wdata       write data to present on the pins
//   rdata       registered read data
//   dq          bidirectional SRAM data pins
`timescale 1ns/1ps
module sram_dq_io
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_wr,
  input  logic              release_wr,
  input  logic              capture,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] dq
);

  logic [DATA_W-1:0] dout_q;
  logic              oe_q;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      oe_q   <= 1'b0;
      rdata  <= '0;
    end else begin
      if (load_wr) begin
        dout_q <= wdata;
        oe_q   <= 1'b1;
      end else if (release_wr) begin
        oe_q   <= 1'b0;
      end
      if (capture) rdata <= dq;
    end
  end

  // NOTE: the pin driver is enabled only by a flop, so the bus cannot glitch
  // onto the SRAM while combinational arbitration settles; reset clears it
  // asynchronously so the pins are released the moment rst_n falls.
  assign dq = oe_q ? dout_q : 'z;

endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter -- two-requester round-robin arbiter and access sequencer
// for a 256K x 16 asynchronous SRAM.
//   CLOCK_50   50 MHz system clock, all state on the rising edge
//   RESET_N    asynchronous active-low reset
//   bus        requester handshake (sram_rr_arbiter_if.slave)
//   SRAM_ADDR  registered word address
//   SRAM_DQ    bidirectional data pins
//   SRAM_*_N   registered active-low strobes
// Read:  IDLE -> RD_ADDR -> RD_DATA -> IDLE, data sampled leaving RD_DATA.
// Write: WR_SETUP -> WR_PULSE (WE_N low one cycle) -> WR_HOLD; WR_HOLD also
//        arbitrates so back-to-back accesses run at three cycles each.
// Build option: define SRAM_ARB_BE_EN to add per-requester byte enables.
`timescale 1ns/1ps
module sram_rr_arbiter
  import sram_arb_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  sram_rr_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N
);

  state_t            state;
  strobe_t           stb;
  logic [1:0]        bstb_n;      // {UB_N, LB_N}
  logic              last_grant;  // also identifies the access in flight
  logic [N_REQ-1:0]  ack_q;
  logic [N_REQ-1:0]  rvalid_q;
  logic [DATA_W-1:0] rdata;

  logic              grant_vld;
  logic              grant_id;
  logic              start;
  logic              start_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        start_bstb_n;

  // Round-robin pick: on contention the requester that did not win last.
  // NOTE: every always_comb output gets a value on every path, so no
  // latches are inferred.
  always_comb begin
    grant_vld = |bus.m_req;
    grant_id  = (bus.m_req == 2'b11) ? ~last_grant : bus.m_req[1];
    start     = grant_vld && (state == IDLE || state == WR_HOLD);
    start_wr  = start && bus.m_we[grant_id];
    sel_addr  = grant_id ? bus.m_addr[2*ADDR_W-1:ADDR_W]
                         : bus.m_addr[ADDR_W-1:0];
    sel_wdata = grant_id ? bus.m_wdata[2*DATA_W-1:DATA_W]
                         : bus.m_wdata[DATA_W-1:0];
`ifdef SRAM_ARB_BE_EN
    // Reads always fetch the full word; writes honour the byte enables.
    start_bstb_n = start_wr ? ~(grant_id ? bus.m_be[3:2] : bus.m_be[1:0])
                            : 2'b00;
`else
    start_bstb_n = 2'b00;
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      stb        <= STB_IDLE;
      bstb_n     <= 2'b11;
      last_grant <= 1'b1;
      SRAM_ADDR  <= '0;
      ack_q      <= '0;
      rvalid_q   <= '0;
    end else begin
      ack_q    <= '0;
      rvalid_q <= '0;
      case (state)
        IDLE, WR_HOLD: begin
          if (start) begin
            state           <= start_wr ? WR_SETUP : RD_ADDR;
            stb             <= start_wr ? STB_WR_SETUP : STB_READ;
            bstb_n          <= start_bstb_n;
            last_grant      <= grant_id;
            SRAM_ADDR       <= sel_addr;
            ack_q[grant_id] <= 1'b1;
          end else begin
            state  <= IDLE;
            stb    <= STB_IDLE;
            bstb_n <= 2'b11;
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          state                <= IDLE;
          stb                  <= STB_IDLE;
          bstb_n               <= 2'b11;
          rvalid_q[last_grant] <= 1'b1;
        end
        WR_SETUP: begin
          state <= WR_PULSE;
          stb   <= STB_WR_PULSE;
        end
        WR_PULSE: begin
          state <= WR_HOLD;
          stb   <= STB_WR_HOLD;
        end
        default: begin
          state  <= IDLE;
          stb    <= STB_IDLE;
          bstb_n <= 2'b11;
        end
      endcase
    end
  end

  assign SRAM_CE_N    = stb.ce_n;
  assign SRAM_OE_N    = stb.oe_n;
  assign SRAM_WE_N    = stb.we_n;
  assign SRAM_UB_N    = bstb_n[1];
  assign SRAM_LB_N    = bstb_n[0];
  assign bus.m_ack    = ack_q;
  assign bus.m_rvalid = rvalid_q;
  assign bus.m_rdata  = rdata;

  // The bus stays driven from WR_SETUP through WR_HOLD; a write granted out
  // of WR_HOLD reloads the data without releasing the pins.
  sram_dq_io u_dq_io (
    .clk        (CLOCK_50),
    .rst_n      (RESET_N),
    .load_wr    (start_wr),
    .release_wr (state == WR_HOLD),
    .capture    (state == RD_DATA),
    .wdata      (sel_wdata),
    .rdata      (rdata),
    .dq         (SRAM_DQ)
  );

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter -- self-checking bench for sram_rr_arbiter with a
// behavioural asynchronous SRAM. Handshake responses are checked by a
// scoreboard; pin timing is checked inline by the directed sequences.
`timescale 1ns/1ps
module tb_sram_rr_arbiter;
  import sram_arb_pkg::*;

  logic              CLOCK_50 = 1'b0;
  logic              RESET_N;
  logic [ADDR_W-1:0] SRAM_ADDR;
  wire  [DATA_W-1:0] SRAM_DQ;
  logic              SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N;

  always #10 CLOCK_50 = ~CLOCK_50;

  sram_rr_arbiter_if bus ();

  sram_rr_arbiter dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_CE_N (SRAM_CE_N)
  );

  // Asynchronous SRAM model: drives on read, latches on the rising WE_N.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 'z;

  always @(posedge SRAM_WE_N) begin
    // A WE_N rise caused by reset is not a completed write: the data bus is
    // released at the same instant.
    if (RESET_N && !SRAM_CE_N) begin
      if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  <= SRAM_DQ[7:0];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected handshake events, in order of occurrence.
  typedef struct packed {
    logic [1:0]  ack;
    logic [1:0]  rvalid;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_ack(input int id);
    exp_t e;
    e = '0;
    e.ack[id] = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input int id, input logic [15:0] data);
    exp_t e;
    e = '0;
    e.rvalid[id] = 1'b1;
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (bus.m_ack != 2'b00 || bus.m_rvalid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {28'd0, bus.m_ack, bus.m_rvalid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_event", {28'd0, bus.m_ack, bus.m_rvalid}, {28'd0, e.ack, e.rvalid});
          if (e.rvalid != 2'b00) check("sb_rdata", {16'd0, bus.m_rdata}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Issue one transaction; returns at the falling edge inside the ack cycle.
  task automatic issue(input int id, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [1:0] be,
                       input logic [DATA_W-1:0] rd_exp);
    bit got;
    push_ack(id);
    if (!we) push_rd(id, rd_exp);
    bus.m_we[id]                      = we;
    bus.m_addr[id*ADDR_W +: ADDR_W]   = addr;
    bus.m_wdata[id*DATA_W +: DATA_W]  = wdata;
`ifdef SRAM_ARB_BE_EN
    bus.m_be[2*id +: 2]               = be;
`else
    if (be != 2'b11) $display("note: byte enables ignored in full-word build");
`endif
    bus.m_req[id] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLOCK_50);
      if (bus.m_ack[id]) got = 1'b1;
    end
    bus.m_req[id] = 1'b0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ack_cyc[$];
    int ack_id[$];

    bus.m_req   = '0;
    bus.m_we    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
`ifdef SRAM_ARB_BE_EN
    bus.m_be    = '1;
`endif
    mem[18'h00010] = 16'hBEEF;
    mem[18'h3FFFF] = 16'h0000;
    mem[18'h00020] = 16'h0F0F;
    mem[18'h00030] = 16'h1111;
    mem[18'h00031] = 16'h2222;
    mem[18'h00040] = 16'hFFFF;
    mem[18'h00055] = 16'h0000;

    // Reset values
    RESET_N = 1'b0;
    idle(2);
    check("rst_strobes", {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
    check("rst_addr",    {14'd0, SRAM_ADDR}, 32'd0);
    check("rst_ack",     {30'd0, bus.m_ack}, 32'd0);
    check("rst_rvalid",  {30'd0, bus.m_rvalid}, 32'd0);
    check("rst_rdata",   {16'd0, bus.m_rdata}, 32'd0);
    check("rst_dq_oe",   {31'd0, dut.u_dq_io.oe_q}, 32'd0);
    RESET_N = 1'b1;
    idle(1);

    // Single read, requester 0
    issue(0, 1'b0, 18'h00010, 16'h0000, 2'b11, 16'hBEEF);
    check("rd_k_strobes", {29'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'b001);
    check("rd_k_addr",    {14'd0, SRAM_ADDR}, 32'h10);
    check("rd_k_lanes",   {30'd0, SRAM_UB_N, SRAM_LB_N}, 32'b00);
    idle(1);
    check("rd_k1_oe",     {31'd0, SRAM_OE_N}, 32'd0);
    idle(1);
    check("rd_k2_idle",   {29'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'b111);
    idle(1);

    // Single write, requester 1, top address
    issue(1, 1'b1, 18'h3FFFF, 16'h1234, 2'b11, 16'h0000);
    check("wr_k_strobes", {29'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'b011);
    check("wr_k_dq",      {16'd0, SRAM_DQ}, 32'h1234);
    idle(1);
    check("wr_k1_we",     {31'd0, SRAM_WE_N}, 32'd0);
    check("wr_k1_oe",     {31'd0, SRAM_OE_N}, 32'd1);
    check("wr_k1_dq",     {16'd0, SRAM_DQ}, 32'h1234);
    idle(1);
    check("wr_k2_we",     {31'd0, SRAM_WE_N}, 32'd1);
    check("wr_k2_dq",     {16'd0, SRAM_DQ}, 32'h1234);
    idle(1);
    check("wr_k3_release", {31'd0, dut.u_dq_io.oe_q}, 32'd0);
    check("wr_k3_ce",      {31'd0, SRAM_CE_N}, 32'd1);
    check("wr_mem",        {16'd0, mem[18'h3FFFF]}, 32'h1234);
    issue(0, 1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'h1234);
    idle(3);

    // Withdrawal: requester 1 pulses m_req while requester 0 is in flight
    issue(0, 1'b0, 18'h00010, 16'h0000, 2'b11, 16'hBEEF);
    bus.m_we[1]     = 1'b1;
    bus.m_addr[35:18] = 18'h00055;
    bus.m_wdata[31:16] = 16'hDEAD;
    bus.m_req[1]    = 1'b1;
    idle(1);
    bus.m_req[1]    = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      check("wd_idle", {30'd0, SRAM_CE_N, SRAM_WE_N}, 32'b11);
      idle(1);
    end
    check("wd_mem", {16'd0, mem[18'h00055]}, 32'h0);

    // Reset asserted during WR_PULSE
    issue(0, 1'b1, 18'h00020, 16'h5A5A, 2'b11, 16'h0000);
    idle(1);
    check("wp_we_low", {31'd0, SRAM_WE_N}, 32'd0);
    #3 RESET_N = 1'b0;
    #1;
    check("wp_rst_strobes", {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
    check("wp_rst_dq_oe",   {31'd0, dut.u_dq_io.oe_q}, 32'd0);
    idle(1);
    RESET_N = 1'b1;
    idle(5);
    check("wp_mem", {16'd0, mem[18'h00020]}, 32'h0F0F);

    // Contention from reset: both requesters read continuously
    RESET_N = 1'b0;
    bus.m_we          = 2'b00;
    bus.m_addr[17:0]  = 18'h00030;
    bus.m_addr[35:18] = 18'h00031;
    for (int i = 0; i < 2; i++) begin
      push_ack(0); push_rd(0, 16'h1111);
      push_ack(1); push_rd(1, 16'h2222);
    end
    bus.m_req = 2'b11;
    idle(1);
    RESET_N = 1'b1;
    for (int c = 0; c < 20 && ack_cyc.size() < 4; c++) begin
      @(negedge CLOCK_50);
      if (bus.m_ack != 2'b00) begin
        ack_cyc.push_back(c);
        ack_id.push_back(bus.m_ack[1] ? 1 : 0);
      end
    end
    bus.m_req = 2'b00;
    check("ct_count", ack_cyc.size(), 32'd4);
    for (int i = 1; i < ack_cyc.size(); i++) begin
      check("ct_spacing", ack_cyc[i] - ack_cyc[i-1], 32'd3);
      check("ct_order", ack_id[i], i % 2);
    end
    idle(4);

`ifdef SRAM_ARB_BE_EN
    // Upper-byte-only write, then full readback
    issue(0, 1'b1, 18'h00040, 16'hAB55, 2'b10, 16'h0000);
    check("be_lanes", {30'd0, SRAM_UB_N, SRAM_LB_N}, 32'b01);
    idle(3);
    issue(0, 1'b0, 18'h00040, 16'h0000, 2'b11, 16'hABFF);
    idle(3);
    check("be_mem", {16'd0, mem[18'h00040]}, 32'hABFF);
`else
    // Full-word write: both byte lanes active
    issue(1, 1'b1, 18'h00040, 16'hAB55, 2'b11, 16'h0000);
    check("fw_lanes", {30'd0, SRAM_UB_N, SRAM_LB_N}, 32'b00);
    idle(3);
    issue(1, 1'b0, 18'h00040, 16'h0000, 2'b11, 16'hAB55);
    idle(3);
    check("fw_mem", {16'd0, mem[18'h00040]}, 32'hAB55);
`endif

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
